fir_output_requant: RTL and testbench

//  Downstream stage of the FIR compiler core: takes its 40-bit full-precision output

---
 rtl/fir_output_requant.sv | 133 +++++++++++++
 tb/tb_fir_output_requant.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_requant.sv
// Rounds/saturates the FIR core's full-precision stream to OUT_W bits and buffers it
// in a show-ahead FIFO behind an AXI-stream master. Optional: FIR_REQUANT_STATS_EN.
module fir_output_requant #(
  parameter int unsigned IN_W       = 40,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned SHIFT      = 15,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          s_axis_tvalid,
  input  logic [IN_W-1:0]               s_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [OUT_W-1:0]              m_axis_tdata,
  output logic                          sat_pulse,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef FIR_REQUANT_STATS_EN
  ,
  output logic [31:0]                   sat_count,
  output logic [31:0]                   drop_count
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic signed [IN_W:0] HALF  = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic                   s1_valid_q, s1_valid_d;
  logic signed [IN_W:0]   s1_data_q, s1_data_d;
  logic signed [IN_W:0]   rnd_sum;
  logic [OUT_W-1:0]       clip_d;
  logic                   clip_hit;
  logic                   sat_pulse_q, sat_pulse_d;
  logic                   overflow_q, overflow_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   pop, full, wr_en, drop;
  logic [OUT_W-1:0]       mem_q [FIFO_DEPTH];

  // Stage 1: round-half-up in IN_W+1 bits so the offset add cannot overflow
  always_comb begin
    rnd_sum    = $signed({s_axis_tdata[IN_W-1], s_axis_tdata}) + HALF;
    s1_valid_d = s_axis_tvalid;
    s1_data_d  = s_axis_tvalid ? (rnd_sum >>> SHIFT) : s1_data_q;
  end

  always_comb begin
    clip_hit = 1'b0;
    clip_d   = s1_data_q[OUT_W-1:0];
    if (s1_data_q > MAX_V) begin
      clip_hit = 1'b1;
      clip_d   = MAX_V[OUT_W-1:0];
    end else if (s1_data_q < MIN_V) begin
      clip_hit = 1'b1;
      clip_d   = MIN_V[OUT_W-1:0];
    end
    sat_pulse_d = s1_valid_q & clip_hit;
  end

  // A pop frees the slot in the same cycle, so full+write+pop never drops
  always_comb begin
    pop        = (level_q != '0) & m_axis_tready;
    full       = (level_q == LVL_W'(FIFO_DEPTH));
    wr_en      = s1_valid_q & (~full | pop);
    drop       = s1_valid_q & full & ~pop;
    level_d    = level_q + LVL_W'(wr_en) - LVL_W'(pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      sat_pulse_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      sat_pulse_q <= sat_pulse_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= clip_d;
  end

  assign m_axis_tvalid = (level_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
  assign sat_pulse     = sat_pulse_q;
  assign overflow      = overflow_q;
  assign level         = level_q;

`ifdef FIR_REQUANT_STATS_EN
  logic [31:0] sat_count_q, sat_count_d, drop_count_q, drop_count_d;

  always_comb begin
    sat_count_d  = sat_count_q;
    drop_count_d = drop_count_q;
    if (sat_pulse_d && sat_count_q != '1) sat_count_d = sat_count_q + 32'd1;
    if (ovf_clr)                           drop_count_d = drop ? 32'd1 : 32'd0;
    else if (drop && drop_count_q != '1)   drop_count_d = drop_count_q + 32'd1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sat_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      sat_count_q  <= sat_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign sat_count  = sat_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_fir_output_requant.sv
// Directed self-checking bench for fir_output_requant (default 40->16, SHIFT 15, depth 8).
module tb_fir_output_requant;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic [39:0] s_axis_tdata = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [15:0] m_axis_tdata;
  logic        sat_pulse;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic [3:0]  level;
`ifdef FIR_REQUANT_STATS_EN
  logic [31:0] sat_count, drop_count;
`endif

  int checks = 0;
  int errors = 0;

  fir_output_requant #(.IN_W(40), .OUT_W(16), .SHIFT(15), .FIFO_DEPTH(8)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .sat_pulse(sat_pulse), .overflow(overflow), .ovf_clr(ovf_clr), .level(level)
`ifdef FIR_REQUANT_STATS_EN
    , .sat_count(sat_count), .drop_count(drop_count)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b0;
    ovf_clr = 1'b0;
    repeat (2) @(posedge aclk);
    #2 areset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, sat_pulse, overflow, level} !== 23'd0) begin
      errors++;
      $display("FAIL reset_state: got tvalid=%b tdata=%h sat=%b ovf=%b level=%0d, want all zero",
               m_axis_tvalid, m_axis_tdata, sat_pulse, overflow, level);
    end
  endtask

  task automatic test_latency();
    apply_reset();
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 40'd32768;
    step();
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: tvalid=%b after 1 cycle, want 0", m_axis_tvalid);
    end
    step();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd1 || sat_pulse !== 1'b0) begin
      errors++;
      $display("FAIL latency_out: tvalid=%b tdata=%0d sat=%b, want 1 1 0",
               m_axis_tvalid, $signed(m_axis_tdata), sat_pulse);
    end
    step();
    checks++;
    if (m_axis_tvalid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL latency_pop: tvalid=%b level=%0d, want 0 0", m_axis_tvalid, level);
    end
  endtask

  task automatic test_rounding();
    logic [39:0] vin [4];
    int          vexp [4];
    vin  = '{40'd16384, 40'd16383, 40'hFFFFFFC000, 40'hFFFFFFBFFF};
    vexp = '{1, 0, 0, -1};
    apply_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = vin[i];
      step();
      s_axis_tvalid = 1'b0;
      step();
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(vexp[i]) || sat_pulse !== 1'b0) begin
        errors++;
        $display("FAIL round_%0d: tvalid=%b tdata=%0d sat=%b, want 1 %0d 0",
                 i, m_axis_tvalid, $signed(m_axis_tdata), sat_pulse, vexp[i]);
      end
      step();
    end
  endtask

  task automatic test_saturation();
    logic [39:0] vin [2];
    logic [15:0] vexp [2];
    vin  = '{40'h0080000000, 40'hFF80000000};
    vexp = '{16'h7FFF, 16'h8000};
    apply_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = vin[i];
      step();
      s_axis_tvalid = 1'b0;
      step();
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== vexp[i] || sat_pulse !== 1'b1) begin
        errors++;
        $display("FAIL sat_%0d: tvalid=%b tdata=%h sat=%b, want 1 %h 1",
                 i, m_axis_tvalid, m_axis_tdata, sat_pulse, vexp[i]);
      end
      step();
      checks++;
      if (sat_pulse !== 1'b0) begin
        errors++;
        $display("FAIL sat_pulse_width_%0d: sat=%b one cycle later, want 0", i, sat_pulse);
      end
    end
`ifdef FIR_REQUANT_STATS_EN
    checks++;
    if (sat_count !== 32'd2) begin
      errors++;
      $display("FAIL sat_count: got %0d, want 2", sat_count);
    end
`endif
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 11; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 40'(i * 32768);
      step();
    end
    s_axis_tvalid = 1'b0;
    step();
    checks++;
    if (level !== 4'd8 || overflow !== 1'b1 || m_axis_tdata !== 16'd1) begin
      errors++;
      $display("FAIL ovf_full: level=%0d ovf=%b head=%0d, want 8 1 1", level, overflow, m_axis_tdata);
    end
`ifdef FIR_REQUANT_STATS_EN
    checks++;
    if (drop_count !== 32'd3) begin
      errors++;
      $display("FAIL drop_count: got %0d, want 3", drop_count);
    end
`endif
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(i)) begin
        errors++;
        $display("FAIL drain_%0d: tvalid=%b tdata=%0d, want 1 %0d", i, m_axis_tvalid, m_axis_tdata, i);
      end
      step();
    end
    checks++;
    if (m_axis_tvalid !== 1'b0 || level !== 4'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: tvalid=%b level=%0d ovf=%b, want 0 0 1", m_axis_tvalid, level, overflow);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%b, want 0", overflow);
    end
`ifdef FIR_REQUANT_STATS_EN
    checks++;
    if (drop_count !== 32'd0) begin
      errors++;
      $display("FAIL drop_count_clr: got %0d, want 0", drop_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int e;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 40'(i * 32768);
      step();
    end
    checks++;
    if (level !== 4'd8 || m_axis_tdata !== 16'd1) begin
      errors++;
      $display("FAIL b2b_fill: level=%0d head=%0d, want 8 1", level, m_axis_tdata);
    end
    m_axis_tready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      s_axis_tdata = 40'((10 + j) * 32768);
      step();
      checks++;
      if (level !== 4'd8 || m_axis_tdata !== 16'(j + 2) || overflow !== 1'b0) begin
        errors++;
        $display("FAIL b2b_full_%0d: level=%0d head=%0d ovf=%b, want 8 %0d 0",
                 j, level, m_axis_tdata, overflow, j + 2);
      end
    end
    s_axis_tvalid = 1'b0;
    e = 7;
    for (int n = 0; n < 20 && m_axis_tvalid === 1'b1; n++) begin
      checks++;
      if (m_axis_tdata !== 16'(e)) begin
        errors++;
        $display("FAIL b2b_order: tdata=%0d, want %0d", m_axis_tdata, e);
      end
      e++;
      step();
    end
    checks++;
    if (e != 16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: next expected=%0d ovf=%b, want 16 0", e, overflow);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 40'(i * 32768);
      step();
    end
    #2 areset = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: tvalid=%b level=%0d, want 0 0", m_axis_tvalid, level);
    end
    s_axis_tvalid = 1'b0;
    #1 areset = 1'b0;
    step();
    step();
    checks++;
    if (m_axis_tvalid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL reset_flush: tvalid=%b level=%0d, want 0 0", m_axis_tvalid, level);
    end
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 40'(7 * 32768);
    step();
    s_axis_tvalid = 1'b0;
    step();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd7 || level !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_out: tvalid=%b tdata=%0d level=%0d, want 1 7 1",
               m_axis_tvalid, m_axis_tdata, level);
    end
    step();
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_alone: tvalid=%b, want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_ovf_set_wins();
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 40'(i * 32768);
      step();
    end
    s_axis_tdata = 40'h0080000000;
    step();
    s_axis_tvalid = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || sat_pulse !== 1'b1 || level !== 4'd8) begin
      errors++;
      $display("FAIL set_wins: ovf=%b sat=%b level=%0d, want 1 1 8", overflow, sat_pulse, level);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || m_axis_tdata !== 16'd1) begin
      errors++;
      $display("FAIL late_clr: ovf=%b head=%0d, want 0 1", overflow, m_axis_tdata);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    test_ovf_set_wins();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
